// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and constants for the two-entry pipeline skid register.
// Holds the occupancy state encoding and the bit positions inside the control field.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;

endpackage

// File: rtl/pipe_skid_reg_sat_cnt.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
// Clear wins over increment; the count sticks at all-ones instead of wrapping.
module pipe_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register (main + skid) with registered ready, flush and a
// saturating count of cycles the head was stalled by downstream.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] dataa_i,
  input  logic [DATA_W-1:0] datab_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] dataa_o,
  output logic [DATA_W-1:0] datab_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  state_t              state_reg, state_next;
  logic                in_ready_reg, out_valid_reg;
  logic [CTRL_W-1:0]   main_ctrl_reg, skid_ctrl_reg;
  logic [DATA_W-1:0]   main_dataa_reg, skid_dataa_reg;
  logic [DATA_W-1:0]   main_datab_reg, skid_datab_reg;
  logic [RD_W-1:0]     main_rd_reg, skid_rd_reg;
  logic                accept, pop;
  logic                load_main, load_skid, move_skid;

  assign accept = in_valid_i & in_ready_reg;
  assign pop    = out_valid_reg & out_ready_i;

  always_comb begin
    state_next = state_reg;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    if (flush_i) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            load_main  = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_next = TWO;
            load_skid  = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          // ready is low in TWO, so only a pop can happen here
          if (pop) begin
            state_next = ONE;
            move_skid  = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_reg      <= EMPTY;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      main_ctrl_reg  <= '0;
      main_dataa_reg <= '0;
      main_datab_reg <= '0;
      main_rd_reg    <= '0;
      skid_ctrl_reg  <= '0;
      skid_dataa_reg <= '0;
      skid_datab_reg <= '0;
      skid_rd_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next != TWO);
      out_valid_reg <= (state_next != EMPTY);
      if (load_main) begin
        main_ctrl_reg  <= ctrl_i;
        main_dataa_reg <= dataa_i;
        main_datab_reg <= datab_i;
        main_rd_reg    <= rd_i;
      end else if (move_skid) begin
        main_ctrl_reg  <= skid_ctrl_reg;
        main_dataa_reg <= skid_dataa_reg;
        main_datab_reg <= skid_datab_reg;
        main_rd_reg    <= skid_rd_reg;
      end
      if (load_skid) begin
        skid_ctrl_reg  <= ctrl_i;
        skid_dataa_reg <= dataa_i;
        skid_datab_reg <= datab_i;
        skid_rd_reg    <= rd_i;
      end
    end
  end

  // A bubble must never assert RegWrite/MemtoReg; data fields just keep their last value.
  assign ctrl_o      = out_valid_reg ? main_ctrl_reg : '0;
  assign dataa_o     = main_dataa_reg;
  assign datab_o     = main_datab_reg;
  assign rd_o        = main_rd_reg;
  assign in_ready_o  = in_ready_reg;
  assign out_valid_o = out_valid_reg;

  pipe_sat_cnt #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (start_i),
    .clr   (flush_i),
    .inc   (out_valid_reg & ~out_ready_i & ~flush_i),
    .cnt   (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: accepted entries go into a scoreboard queue,
// a monitor pops and compares on every downstream handshake.
module tb_pipe_skid_reg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int CTRL_W = 2;
  localparam int CNT_W  = 2;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [RD_W-1:0]   rd;
  } item_t;

  logic              clk;
  logic              start;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] dataa_in;
  logic [DATA_W-1:0] datab_in;
  logic [RD_W-1:0]   rd_in;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] dataa_out;
  logic [DATA_W-1:0] datab_out;
  logic [RD_W-1:0]   rd_out;
  logic [CNT_W-1:0]  stall_cnt;

  int    checks = 0;
  int    fails  = 0;
  item_t sb_q[$];

  pipe_skid_reg #(
    .DATA_W (DATA_W),
    .RD_W   (RD_W),
    .CTRL_W (CTRL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i       (clk),
    .start_i     (start),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .ctrl_i      (ctrl_in),
    .dataa_i     (dataa_in),
    .datab_i     (datab_in),
    .rd_i        (rd_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .ctrl_o      (ctrl_out),
    .dataa_o     (dataa_out),
    .datab_o     (datab_out),
    .rd_o        (rd_out),
    .stall_cnt_o (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] a);
    in_valid = 1'b1;
    ctrl_in  = c;
    dataa_in = a;
    datab_in = a ^ 32'hA5A5_0000;
    rd_in    = a[RD_W-1:0];
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Stimulus side: record every entry the DUT takes at the coming edge.
  always @(negedge clk) begin
    item_t it;
    if (!start || flush) begin
      sb_q.delete();
    end else if (in_valid && in_ready) begin
      it.ctrl = ctrl_in;
      it.a    = dataa_in;
      it.b    = datab_in;
      it.rd   = rd_in;
      sb_q.push_back(it);
    end
  end

  // Monitor side: every downstream handshake must match the oldest recorded entry.
  always @(negedge clk) begin
    item_t exp_it;
    item_t act_it;
    if (start && !flush && out_valid && out_ready) begin
      act_it.ctrl = ctrl_out;
      act_it.a    = dataa_out;
      act_it.b    = datab_out;
      act_it.rd   = rd_out;
      checks++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got entry a=%0h with nothing expected", dataa_out);
      end else begin
        exp_it = sb_q.pop_front();
        if (act_it !== exp_it) begin
          fails++;
          $display("FAIL sb_payload: got %0h expected %0h", act_it, exp_it);
        end else begin
          $display("ok   sb_payload: a=%0h ctrl=%0h", dataa_out, ctrl_out);
        end
      end
    end
  end

  initial begin
    start     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ctrl_in   = '0;
    dataa_in  = '0;
    datab_in  = '0;
    rd_in     = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ctrl", 32'(ctrl_out), 32'd0);
    check("rst_dataa", dataa_out, 32'd0);
    check("rst_datab", datab_out, 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);

    // pass-through, first accept right after reset release
    start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(2'b01, 32'(i));
      step();
      check("pt_valid", 32'(out_valid), 32'd1);
      check("pt_dataa", dataa_out, 32'(i));
      check("pt_ctrl", 32'(ctrl_out), 32'd1);
    end
    idle();
    step();
    check("pt_drain_valid", 32'(out_valid), 32'd0);
    check("pt_drain_hold", dataa_out, 32'd3);

    // bubble after a RegWrite+MemtoReg entry
    drive(2'b11, 32'h55);
    step();
    check("bub_ctrl_live", 32'(ctrl_out), 32'd3);
    idle();
    step();
    check("bub_valid", 32'(out_valid), 32'd0);
    check("bub_ctrl", 32'(ctrl_out), 32'd0);
    check("bub_dataa_hold", dataa_out, 32'h55);
    check("bub_rd_hold", 32'(rd_out), 32'h15);

    // backpressure into TWO
    out_ready = 1'b0;
    drive(2'b01, 32'h10);
    step();
    check("bp_one_ready", 32'(in_ready), 32'd1);
    check("bp_one_dataa", dataa_out, 32'h10);
    check("bp_one_stall", 32'(stall_cnt), 32'd0);
    drive(2'b01, 32'h20);
    step();
    check("bp_two_ready", 32'(in_ready), 32'd0);
    check("bp_two_dataa", dataa_out, 32'h10);
    check("bp_two_stall", 32'(stall_cnt), 32'd1);
    drive(2'b01, 32'h30);
    step();
    check("bp_c_blocked", 32'(in_ready), 32'd0);
    check("bp_c_head", dataa_out, 32'h10);
    check("bp_c_stall", 32'(stall_cnt), 32'd2);
    out_ready = 1'b1;
    step();
    check("bp_rel_b", dataa_out, 32'h20);
    check("bp_rel_ready", 32'(in_ready), 32'd1);
    check("bp_rel_stall", 32'(stall_cnt), 32'd2);
    step();
    check("bp_rel_c", dataa_out, 32'h30);
    idle();
    step();
    check("bp_empty", 32'(out_valid), 32'd0);

    // flush while full with an incoming entry
    out_ready = 1'b0;
    drive(2'b01, 32'h40);
    step();
    drive(2'b01, 32'h50);
    step();
    check("fl_two_ready", 32'(in_ready), 32'd0);
    check("fl_two_stall", 32'(stall_cnt), 32'd3);
    drive(2'b11, 32'h60);
    flush = 1'b1;
    step();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ctrl", 32'(ctrl_out), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    check("fl_stall", 32'(stall_cnt), 32'd0);
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_nothing", 32'(out_valid), 32'd0);
    end

    // stall counter saturation with a single entry held
    out_ready = 1'b0;
    drive(2'b01, 32'h70);
    step();
    idle();
    check("sat_start", 32'(stall_cnt), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      step();
      check("sat_cnt", 32'(stall_cnt), (i < 3) ? 32'(i) : 32'd3);
    end
    out_ready = 1'b1;
    step();
    check("sat_pop", 32'(out_valid), 32'd0);

    // reset asserted while full
    out_ready = 1'b0;
    drive(2'b01, 32'h80);
    step();
    drive(2'b11, 32'h90);
    step();
    check("mr_two_ready", 32'(in_ready), 32'd0);
    drive(2'b11, 32'hA0);
    start = 1'b0;
    #1;
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_ready", 32'(in_ready), 32'd1);
    check("mr_ctrl", 32'(ctrl_out), 32'd0);
    check("mr_dataa", dataa_out, 32'd0);
    check("mr_datab", datab_out, 32'd0);
    check("mr_rd", 32'(rd_out), 32'd0);
    check("mr_stall", 32'(stall_cnt), 32'd0);
    step();
    check("mr_no_accept", 32'(out_valid), 32'd0);
    start = 1'b1;
    idle();
    step();
    check("mr_after", 32'(out_valid), 32'd0);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
